// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants, ALU function encoding and the issue bundle
// held by the decode/issue pipeline register.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Shifts keep the shifter type in the low two bits.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_SRL  = 4'b1100,
        ALU_SLL  = 4'b1101,
        ALU_SRA  = 4'b1110
    } alufn_e;

    localparam logic [1:0] SH_SRL = 2'b00;
    localparam logic [1:0] SH_SLL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      shamt;
        logic [3:0]      alufn;
        logic [4:0]      rd;
        logic            we;
        logic            illegal;
    } ex_bundle_t;

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{(XLEN-12){instr[31]}}, instr[31:20]};
    endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational OP / OP-IMM decode into ALU function, shift amount,
// operand B, write enable and illegal flag.
module op_decode
    import riscv_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs2,
    output logic [3:0]      alufn,
    output logic [4:0]      shamt,
    output logic [XLEN-1:0] op_b,
    output logic            we,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_op;
    logic       is_imm;
    logic [4:0] sh_src;
    alufn_e     fn;
    logic       ill;
    logic       unused_rs1_field;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign is_op  = (opcode == OPC_OP);
    assign is_imm = (opcode == OPC_OP_IMM);
    assign sh_src = is_imm ? instr[24:20] : rs2[4:0];
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        fn    = ALU_ADD;
        ill   = 1'b0;
        shamt = 5'd0;
        if (!is_op && !is_imm) begin
            ill = 1'b1;
        end else begin
            case (f3)
                F3_ADD: begin
                    if (is_op && f7 == F7_ALT)       fn  = ALU_SUB;
                    else if (is_op && f7 != F7_BASE) ill = 1'b1;
                end
                F3_SLL: begin
                    if (f7 == F7_BASE) begin
                        fn    = ALU_SLL;
                        shamt = sh_src;
                    end else begin
                        ill = 1'b1;
                    end
                end
                F3_SR: begin
                    if (f7 == F7_BASE) begin
                        fn    = ALU_SRL;
                        shamt = sh_src;
                    end else if (f7 == F7_ALT) begin
                        fn    = ALU_SRA;
                        shamt = sh_src;
                    end else begin
                        ill = 1'b1;
                    end
                end
                default: begin
                    // OP-IMM ignores funct7 outside shifts; OP must have it clear.
                    if (is_op && f7 != F7_BASE) begin
                        ill = 1'b1;
                    end else begin
                        case (f3)
                            F3_SLT:  fn = ALU_SLT;
                            F3_SLTU: fn = ALU_SLTU;
                            F3_XOR:  fn = ALU_XOR;
                            F3_OR:   fn = ALU_OR;
                            default: fn = ALU_AND;
                        endcase
                    end
                end
            endcase
        end
    end

    assign alufn   = fn;
    assign illegal = ill;
    assign we      = !ill && (instr[11:7] != 5'd0);
    assign op_b    = is_imm ? imm_i(instr) : rs2;

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage: single pipeline register with valid/ready backpressure
// and flush, presenting one decoded bundle at a time to the shifter and ALU.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [4:0]      out_shamt,
    output logic [3:0]      out_alufn,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal
);

    ex_bundle_t bundle_q, bundle_d, dec_bundle;
    logic       valid_q, valid_d;
    logic       accept;

    op_decode u_op_decode (
        .instr   (in_instr),
        .rs2     (in_rs2),
        .alufn   (dec_bundle.alufn),
        .shamt   (dec_bundle.shamt),
        .op_b    (dec_bundle.b),
        .we      (dec_bundle.we),
        .illegal (dec_bundle.illegal)
    );

    assign dec_bundle.pc = in_pc;
    assign dec_bundle.a  = in_rs1;
    assign dec_bundle.rd = in_instr[11:7];

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Flush wins: it drops the held bundle and discards anything accepted.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec_bundle;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = bundle_q.pc;
    assign out_a       = bundle_q.a;
    assign out_b       = bundle_q.b;
    assign out_shamt   = bundle_q.shamt;
    assign out_alufn   = bundle_q.alufn;
    assign out_rd      = bundle_q.rd;
    assign out_we      = bundle_q.we;
    assign out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed encodings, backpressure,
// flush, async reset and randomized traffic against a behavioural model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_ready, out_valid;
    logic [31:0] in_instr, in_pc, in_rs1, in_rs2;
    logic [31:0] out_pc, out_a, out_b;
    logic [4:0]  out_shamt, out_rd;
    logic [3:0]  out_alufn;
    logic        out_we, out_illegal;

    int checks = 0;
    int errors = 0;

    // Model state: held valid, held bundle fields, and which bits are defined.
    logic         m_valid;
    logic [111:0] m_dat;
    logic [111:0] m_mask;
    logic         rdy_obs, rdy_exp;

    wire [111:0] obs_dat = {out_pc, out_a, out_b, out_shamt, out_alufn, out_rd, out_we, out_illegal};

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_pc(out_pc), .out_a(out_a), .out_b(out_b), .out_shamt(out_shamt),
        .out_alufn(out_alufn), .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    // Layout: pc[111:80] a[79:48] b[47:16] shamt[15:11] alufn[10:7] rd[6:2] we[1] ill[0]
    function automatic logic [111:0] ref_bundle(input logic [31:0] instr, pc, rs1, rs2);
        logic [6:0]  opc = instr[6:0];
        logic [2:0]  f3  = instr[14:12];
        logic [6:0]  f7  = instr[31:25];
        logic        is_op  = (opc == 7'h33);
        logic        is_imm = (opc == 7'h13);
        logic        shift  = (f3 == 3'd1) || (f3 == 3'd5);
        logic        ill = 1'b0;
        logic [3:0]  fn  = 4'b0000;
        logic [4:0]  sh  = 5'd0;
        logic [31:0] b;
        logic        we;
        if (!is_op && !is_imm) begin
            ill = 1'b1;
        end else if (shift) begin
            ill = !(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20));
            if (!ill) begin
                if (f3 == 3'd1)       fn = 4'b1101;
                else if (f7 == 7'h00) fn = 4'b1100;
                else                  fn = 4'b1110;
                sh = is_imm ? instr[24:20] : rs2[4:0];
            end
        end else begin
            ill = is_op && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0));
            if (!ill) begin
                case (f3)
                    3'd0:    fn = (is_op && f7 == 7'h20) ? 4'b0001 : 4'b0000;
                    3'd2:    fn = 4'b1000;
                    3'd3:    fn = 4'b1001;
                    3'd4:    fn = 4'b0110;
                    3'd6:    fn = 4'b0101;
                    default: fn = 4'b0100;
                endcase
            end
        end
        b  = is_imm ? {{20{instr[31]}}, instr[31:20]} : rs2;
        we = !ill && (instr[11:7] != 5'd0);
        return {pc, rs1, b, sh, fn, instr[11:7], we, ill};
    endfunction

    // Operand B is only defined for OP/OP-IMM; shamt only for legal encodings.
    function automatic logic [111:0] ref_mask(input logic [31:0] instr);
        logic [111:0] m = '1;
        logic [1:0]   ill = ref_bundle(instr, 32'd0, 32'd0, 32'd0) & 112'h1;
        if (instr[6:0] != 7'h33 && instr[6:0] != 7'h13) m[47:16] = '0;
        if (ill[0]) m[15:11] = '0;
        return m;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_dat   = '0;
        m_mask  = '1;
    endtask

    task automatic step(input logic iv, input logic [31:0] instr, pc, rs1, rs2,
                        input logic ordy, input logic fl);
        in_valid  = iv;
        in_instr  = instr;
        in_pc     = pc;
        in_rs1    = rs1;
        in_rs2    = rs2;
        out_ready = ordy;
        flush     = fl;
        #1;
        rdy_obs = in_ready;
        rdy_exp = !m_valid || ordy;
        if (fl) begin
            m_valid = 1'b0;
        end else if (iv && rdy_exp) begin
            m_valid = 1'b1;
            m_dat   = ref_bundle(instr, pc, rs1, rs2);
            m_mask  = ref_mask(instr);
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b1, 32'h40315093, 32'h10, 32'h1, 32'h2, 1'b1, 1'b0);
        model_reset();
        checks++;
        if ({out_valid, obs_dat, in_ready} !== {1'b0, 112'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b dat=%h rdy=%b want valid=0 dat=0 rdy=1",
                     out_valid, obs_dat, in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        step(1'b1, 32'h40315093, 32'h100, 32'h80000000, 32'h1234, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_alufn, out_shamt, out_rd, out_we, out_illegal, out_a, out_b, out_pc} !==
            {1'b1, 4'b1110, 5'd3, 5'd1, 1'b1, 1'b0, 32'h80000000, 32'h00000403, 32'h100}) begin
            errors++;
            $display("FAIL srai: got v=%b fn=%b sh=%0d rd=%0d we=%b ill=%b a=%h b=%h pc=%h want v=1 fn=1110 sh=3 rd=1 we=1 ill=0 a=80000000 b=403 pc=100",
                     out_valid, out_alufn, out_shamt, out_rd, out_we, out_illegal, out_a, out_b, out_pc);
        end
        step(1'b1, 32'h005211B3, 32'h104, 32'h7, 32'h25, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_alufn, out_shamt, out_rd, out_we, out_illegal, out_b} !==
            {1'b1, 4'b1101, 5'd5, 5'd3, 1'b1, 1'b0, 32'h25}) begin
            errors++;
            $display("FAIL sll: got fn=%b sh=%0d rd=%0d we=%b ill=%b b=%h want fn=1101 sh=5 rd=3 we=1 ill=0 b=25",
                     out_alufn, out_shamt, out_rd, out_we, out_illegal, out_b);
        end
        step(1'b1, 32'h40311093, 32'h108, 32'h7, 32'h8, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_alufn, out_we, out_illegal} !== {1'b1, 4'b0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL slli_bad_f7: got fn=%b we=%b ill=%b want fn=0000 we=0 ill=1",
                     out_alufn, out_we, out_illegal);
        end
        step(1'b1, 32'h40000033, 32'h10c, 32'h7, 32'h8, 1'b1, 1'b0);
        checks++;
        if ({out_alufn, out_we, out_illegal, out_shamt} !== {4'b0001, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL sub_rd0: got fn=%b we=%b ill=%b sh=%0d want fn=0001 we=0 ill=0 sh=0",
                     out_alufn, out_we, out_illegal, out_shamt);
        end
        step(1'b1, 32'h400070B3, 32'h110, 32'h7, 32'h8, 1'b1, 1'b0);
        checks++;
        if ({out_alufn, out_we, out_illegal} !== {4'b0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL op_and_f7alt: got fn=%b we=%b ill=%b want fn=0000 we=0 ill=1",
                     out_alufn, out_we, out_illegal);
        end
        step(1'b1, 32'h000010B7, 32'h114, 32'h7, 32'h8, 1'b1, 1'b0);
        checks++;
        if ({out_alufn, out_we, out_illegal, out_shamt, out_rd} !== {4'b0000, 1'b0, 1'b1, 5'd0, 5'd1}) begin
            errors++;
            $display("FAIL other_opcode: got fn=%b we=%b ill=%b sh=%0d rd=%0d want fn=0000 we=0 ill=1 sh=0 rd=1",
                     out_alufn, out_we, out_illegal, out_shamt, out_rd);
        end
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_rd, out_pc} !== {1'b0, 5'd1, 32'h114}) begin
            errors++;
            $display("FAIL consume_keeps_data: got v=%b rd=%0d pc=%h want v=0 rd=1 pc=114",
                     out_valid, out_rd, out_pc);
        end
    endtask

    task automatic test_backpressure();
        logic [111:0] hold_a;
        step(1'b1, 32'hFFF00293, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0);
        hold_a = ref_bundle(32'hFFF00293, 32'h200, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0083C333, 32'h204, 32'h55, 32'hAA, 1'b0, 1'b0);
            checks++;
            if ({rdy_obs, out_valid, obs_dat} !== {1'b0, 1'b1, hold_a}) begin
                errors++;
                $display("FAIL bp_hold%0d: got rdy=%b v=%b dat=%h want rdy=0 v=1 dat=%h",
                         i, rdy_obs, out_valid, obs_dat, hold_a);
            end
        end
        step(1'b1, 32'h0083C333, 32'h204, 32'h55, 32'hAA, 1'b1, 1'b0);
        checks++;
        if ({rdy_obs, out_valid, out_pc, out_alufn, out_rd, out_b} !==
            {1'b1, 1'b1, 32'h204, 4'b0110, 5'd6, 32'hAA}) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b v=%b pc=%h fn=%b rd=%0d b=%h want rdy=1 v=1 pc=204 fn=0110 rd=6 b=aa",
                     rdy_obs, out_valid, out_pc, out_alufn, out_rd, out_b);
        end
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        step(1'b1, 32'hFFF00293, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h0083C333, 32'h304, 32'h1, 32'h2, 1'b1, 1'b1);
        checks++;
        if ({rdy_obs, out_valid, out_pc} !== {1'b1, 1'b0, 32'h300}) begin
            errors++;
            $display("FAIL flush_drop: got rdy=%b v=%b pc=%h want rdy=1 v=0 pc=300",
                     rdy_obs, out_valid, out_pc);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if ({out_valid, out_pc} !== {1'b0, 32'h300}) begin
                errors++;
                $display("FAIL flush_no_b%0d: got v=%b pc=%h want v=0 pc=300", i, out_valid, out_pc);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'hFFF00293, 32'h400, 32'h9, 32'h9, 1'b0, 1'b0);
        step(1'b1, 32'h0083C333, 32'h404, 32'h1, 32'h2, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({out_valid, obs_dat, in_ready} !== {1'b0, 112'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got v=%b dat=%h rdy=%b want v=0 dat=0 rdy=1",
                     out_valid, obs_dat, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h0083C333, 32'h404, 32'h1, 32'h2, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_pc, out_alufn, out_rd, out_we} !== {1'b1, 32'h404, 4'b0110, 5'd6, 1'b1}) begin
            errors++;
            $display("FAIL post_reset_accept: got v=%b pc=%h fn=%b rd=%0d we=%b want v=1 pc=404 fn=0110 rd=6 we=1",
                     out_valid, out_pc, out_alufn, out_rd, out_we);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, instr;
        logic [6:0]  opc, f7;
        int          sel;
        for (int i = 0; i < 400; i++) begin
            r   = $urandom;
            sel = $urandom_range(0, 9);
            opc = (sel < 4) ? 7'h33 : (sel < 8) ? 7'h13 : r[6:0];
            sel = $urandom_range(0, 5);
            f7  = (sel < 3) ? 7'h00 : (sel < 5) ? 7'h20 : r[31:25];
            instr = {f7, r[24:7], opc};
            step($urandom_range(0, 9) < 7, instr, $urandom, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
            checks++;
            if (rdy_obs !== rdy_exp) begin
                errors++;
                $display("FAIL rand_in_ready%0d: got %b want %b", i, rdy_obs, rdy_exp);
            end
            checks++;
            if ({out_valid, obs_dat & m_mask} !== {m_valid, m_dat & m_mask}) begin
                errors++;
                $display("FAIL rand_out%0d: got v=%b dat=%h want v=%b dat=%h",
                         i, out_valid, obs_dat & m_mask, m_valid, m_dat & m_mask);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        in_valid = 1'b0; in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Registered decode/issue stage feeding the execute-stage shifter and ALU. It accepts one decoded-operand bundle per handshake from the register-read stage and decodes OP and OP-IMM instructions into an ALU function code; `alufn[1:0]` is the shifter type. It holds the result in a single pipeline register with valid/ready backpressure and flush, so the shifter and ALU see stable operands for exactly one accepted instruction at a time.

## Interface
- `XLEN`, 32, datapath width
- `clk` input 1: clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: upstream bundle valid
- `in_ready` output 1: stage can accept this cycle
- `in_instr` input 32: raw instruction
- `in_pc` input XLEN: instruction PC
- `in_rs1` input XLEN: rs1 register value
- `in_rs2` input XLEN: rs2 register value
- `flush` input 1: kill held and incoming instruction
- `out_ready` input 1: execute stage consumes this cycle
- `out_valid` output 1: held bundle valid
- `out_pc` output XLEN: registered PC
- `out_a` output XLEN: operand A (= rs1)
- `out_b` output XLEN: operand B (rs2, or sign-extended I-immediate)
- `out_shamt` output 5: shift amount
- `out_alufn` output 4: ALU function; `[1:0]` is the shifter type for shifts
- `out_rd` output 5: destination register
- `out_we` output 1: register write enable
- `out_illegal` output 1: unsupported or malformed OP/OP-IMM encoding

## Operation
- Opcodes decoded: 0110011 (OP) and 0010011 (OP-IMM). Any other opcode gives `alufn`=ADD, `we`=0, `illegal`=1.
- `alufn` encoding:
  - ADD 0000, SUB 0001, AND 0100, OR 0101, XOR 0110, SLT 1000, SLTU 1001
  - SRL 1100, SLL 1101, SRA 1110
  - Shift type = `alufn[1:0]`: 00 srl, 01 sll, 10 sra.
- Shifts:
  - funct3 001 requires funct7 0000000 → SLL.
  - funct3 101: funct7 0000000 → SRL; funct7 0100000 → SRA.
  - Any other funct7 → `illegal`=1, `we`=0, `alufn`=ADD.
  - `shamt` = `instr[24:20]` for OP-IMM, `rs2[4:0]` for OP.
- Non-shift instructions: `shamt`=0.
- OP with funct7 0100000 is legal only for funct3 000 (SUB); otherwise `illegal`.
- OP-IMM: funct3 000 ADDI; funct7 is ignored except for shifts. `out_b` = sign-extended `instr[31:20]`.
- `rd` = `instr[11:7]`. `we` = legal AND `rd`≠0.

## Timing
- Latency: one cycle from accept to `out_valid`.
- `in_ready` = `!out_valid || out_ready` (combinational; no skid buffer).
- Accept when `in_valid && in_ready`: all `out_*` fields load at the next edge and `out_valid` is set to 1.
- Consume (`out_valid && out_ready`) without an accept in the same cycle: `out_valid` clears to 0; data fields keep their last values.
- Consume and accept in the same cycle: the new bundle replaces the old one; `out_valid` stays 1 with no bubble.
- `out_valid && !out_ready`: all outputs hold bit-stable.
- `flush`=1 takes priority over everything:
  - `out_valid` clears to 0 at the next edge.
  - Any input accepted that cycle is discarded.
  - `in_ready` still follows its formula.
- Reset (async assert, at any time, including mid-hold): all outputs 0, `out_valid`=0, `in_ready`=1. Release is synchronous to `clk`.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants
  - funct3/funct7 constants
  - `alufn` enum (values above)
  - shift-type constants `SH_SRL`/`SH_SLL`/`SH_SRA`
- Sub-module `op_decode`: purely combinational, maps instr/rs2 to alufn/shamt/imm/we/illegal.
- Top level: handshake control and the pipeline register.

## Test plan
- SRAI x1,x2,3 (`0x40315093`), rs1=`0x80000000`, out_ready=1 → next cycle out_valid=1, alufn=1110, shamt=3, rd=1, we=1, illegal=0.
- SLL x3,x4,x5 (`0x005211B3`), rs2=`0x00000025` → shamt=5, alufn=1101, out_b=`0x25`.
- SLLI with funct7 0100000 (`0x40311093`) → illegal=1, we=0, alufn=0000.
- Backpressure:
  - Accept A with out_ready=0 for 3 cycles while in_valid stays high with B → in_ready=0 and outputs stay A.
  - out_ready=1 → B loads next cycle with no bubble.
- Flush while holding A with in_valid=1 (B) → out_valid=0 next cycle; B not presented afterwards.
- Assert rst_n=0 asynchronously mid-hold → out_valid and all outputs 0 immediately; after release, the first accept behaves normally.
